uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of payload bits per frame.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous, active-low reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance.
REQ-005 Data_Valid  input  1  request to send P_DATA; single-cycle pulse or level.
REQ-006 PAR_EN  input  1  1 = insert parity bit in frame; sampled on acceptance.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
REQ-008 TX_OUT  output  1  registered serial line, idle high.
REQ-009 Busy  output  1  registered; high while a frame is in progress.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; one bit per clock per state slot.
REQ-011 IDLE: TX_OUT=1, Busy=0; Data_Valid=1 at edge N SHALL capture P_DATA, PAR_EN, PAR_TYP and go to START.
REQ-012 START: TX_OUT=0 and Busy=1 from cycle N+1, one cycle, then DATA.
REQ-013 DATA: DATA_WIDTH cycles, LSB first; bit counter 0..DATA_WIDTH-1; at DATA_WIDTH-1 go to PARITY if captured PAR_EN=1, else STOP.
REQ-014 PARITY: one cycle, TX_OUT = XOR-reduce(captured data) when even, its inverse when odd.
REQ-015 STOP: one cycle TX_OUT=1, Busy=1; then IDLE with Busy=0 next cycle.
REQ-016 Frame length SHALL be DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
REQ-017 Data_Valid while Busy=1 (including STOP cycle) SHALL be ignored; no queuing.
REQ-018 Changes of P_DATA/PAR_EN/PAR_TYP after acceptance SHALL not affect the current frame.
REQ-019 Minimum gap between frames: one IDLE cycle (TX_OUT=1) after STOP.
REQ-020 Bit counter SHALL reset to 0 on entering DATA; no wrap beyond DATA_WIDTH-1.

Reset
REQ-021 RST=0 at any edge SHALL force IDLE, TX_OUT=1, Busy=0, counter=0, captured data=0.
REQ-022 Reset mid-frame SHALL abort the frame; no partial completion after RST returns high.
REQ-023 Data_Valid during RST=0 SHALL be ignored.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: defined -> PARITY state and PAR_EN/PAR_TYP behave per REQ-013/014.
REQ-025 Undefined -> PARITY state and parity logic absent, PAR_EN/PAR_TYP ignored, frame always DATA_WIDTH+2 cycles; ports remain.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum, START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
REQ-027 One sub-module uart_tx_serializer (load, shift enable, LSB-first shift register, serial bit out); FSM and parity remain in uart_tx_ctrl.

Verification
REQ-028 P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, pulse Data_Valid -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 then idle 1; Busy high 11 cycles.
REQ-029 P_DATA=8'hA5, PAR_EN=1, PAR_TYP=1 -> parity slot 1; P_DATA=8'h00 odd -> parity 1, even -> 0.
REQ-030 PAR_EN=0, P_DATA=8'hFF -> 0, eight 1s, stop 1; Busy high exactly 10 cycles.
REQ-031 Data_Valid held high continuously with 8'h3C then 8'hC3 -> second frame starts only after one IDLE cycle; pulses during Busy produce no extra frame.
REQ-032 RST=0 during DATA bit 4 -> next cycle TX_OUT=1, Busy=0; after release no residual bits until new Data_Valid.
REQ-033 Build without UART_TX_PARITY_EN, PAR_EN=1 -> frame 10 cycles, no parity slot.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and line levels.
// Build option: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request/serial-line bundle between a UART TX requester and uart_tx_ctrl.
// PAR_EN/PAR_TYP stay on the bundle in every build (UART_TX_PARITY_EN only changes their use).
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first payload shift register; ser_bit_c is the bit currently at the LSB.
// Independent of UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_bit_c
);

    logic [DATA_WIDTH-1:0] shreg_q;

    // Load wins over shift; the controller never asserts both together.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift_en) begin
            shreg_q <= shreg_q >> 1;
        end
    end

    assign ser_bit_c = shreg_q[0];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a word, sends start/data/[parity]/stop with registered line and Busy.
// Build option: define UART_TX_PARITY_EN to enable the optional parity slot (PAR_EN/PAR_TYP).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  tx_if
);

    localparam int unsigned           CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  tx_out_q;
    logic                  tx_out_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  load_c;
    logic                  shift_c;
    logic                  ser_bit_c;
    logic [DATA_WIDTH-1:0] p_data_c;

    assign p_data_c = tx_if.P_DATA;

`ifdef UART_TX_PARITY_EN
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  parity_c;

    // Frame settings frozen at acceptance so later input changes cannot leak in.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (load_c) begin
            data_q    <= p_data_c;
            par_en_q  <= tx_if.PAR_EN;
            par_typ_q <= tx_if.PAR_TYP;
        end
    end

    assign parity_c = (^data_q) ^ par_typ_q;
`else
    logic unused_par_c;
    assign unused_par_c = tx_if.PAR_EN ^ tx_if.PAR_TYP;
`endif

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load_c),
        .shift_en  (shift_c),
        .load_data (p_data_c),
        .ser_bit_c (ser_bit_c)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the line/Busy values that state will present, so outputs register alongside it.
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        shift_c  = 1'b0;
        tx_out_d = IDLE_LEVEL;
        cnt_d    = '0;

        case (state_q)
            IDLE: begin
                if (tx_if.Data_Valid) begin
                    state_d = START;
                    load_c  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_d = STOP;
            end
`endif
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START: tx_out_d = START_BIT;
            DATA: begin
                tx_out_d = ser_bit_c;
                shift_c  = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: tx_out_d = parity_c;
`endif
            STOP:    tx_out_d = STOP_BIT;
            default: tx_out_d = IDLE_LEVEL;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q    <= '0;
            tx_out_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.Busy   = busy_q;

endmodule
